etapa_if: RTL and testbench
===========================

ETAPA_IF -- requirements
Module: etapa_if

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter BUBBLE, default 32'h0000_0000, instruction word inserted into IF/ID on flush or reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 SEL_DIR  input  2  next-PC select from control: 00 PC+4, 01 jump j, 10 jump jr, 11 reserved.
REQ-006 resetIF  input  1  active-high flush of IF/ID (jump taken in ID).
REQ-007 stall  input  1  active-high hazard stall; freezes PC and IF/ID.
REQ-008 jr_addr  input  32  rs register value from ID, jr target.
REQ-009 imem_data  input  32  instruction memory read data, combinational on imem_addr.
REQ-010 imem_addr  output  32  current PC to instruction memory.
REQ-011 imem_rd_n  output  1  active-low instruction memory read enable.
REQ-012 ifid_instr  output  32  IF/ID instruction register.
REQ-013 ifid_pc4  output  32  IF/ID PC+4 of held instruction.
REQ-014 ifid_valid  output  1  IF/ID holds a real fetched instruction.
REQ-015 opcode  output  6  ifid_instr[31:26], to control decoder.
REQ-016 funct  output  6  ifid_instr[5:0], to control decoder.
REQ-017 flush_cnt  output  16  count of flushes, saturating at 16'hFFFF.

Function
REQ-018 Per-edge priority SHALL be: rst_n low > stall > redirect (resetIF or SEL_DIR!=00) > sequential.
REQ-019 Sequential (stall=0, SEL_DIR=00, resetIF=0): PC <= PC+4; ifid_instr <= imem_data; ifid_pc4 <= PC+4; ifid_valid <= 1.
REQ-020 SEL_DIR=01 target SHALL be {ifid_pc4[31:28], ifid_instr[25:0], 2'b00}.
REQ-021 SEL_DIR=10 target SHALL be jr_addr with bits [1:0] forced to 00.
REQ-022 SEL_DIR=11 SHALL behave as 00.
REQ-023 Redirect with stall=0: PC <= target same edge; fetch latency from jump in ID to target in IF/ID is 2 edges.
REQ-024 resetIF=1 with stall=0: ifid_instr <= BUBBLE, ifid_valid <= 0, ifid_pc4 <= 0; instruction fetched that cycle discarded; flush_cnt increments unless saturated.
REQ-025 SEL_DIR!=00 with resetIF=0 SHALL still redirect PC but load IF/ID normally (no implicit flush).
REQ-026 stall=1: PC, IF/ID, flush_cnt hold; resetIF and SEL_DIR ignored that edge; imem_rd_n = 1.
REQ-027 imem_rd_n SHALL be 0 whenever rst_n=1 and stall=0; imem_addr = PC at all times.
REQ-028 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no error.
REQ-029 opcode and funct SHALL be purely combinational slices of ifid_instr.

Reset
REQ-030 rst_n low SHALL immediately force PC=RESET_PC, ifid_instr=BUBBLE, ifid_pc4=0, ifid_valid=0, flush_cnt=0, imem_rd_n=1, regardless of clk.
REQ-031 First edge after rst_n release SHALL fetch from RESET_PC; reset mid-redirect or mid-stall discards all pending state.

Structure
REQ-032 RESET_PC, BUBBLE and SEL_DIR encodings (00/01/10) SHALL live in the shared processor constants package used by the control decoder.
REQ-033 One sub-module, pc_next, SHALL hold the combinational next-PC mux (PC+4, j target, jr target); PC and IF/ID registers stay in etapa_if.

Verification
REQ-034 Reset release, RESET_PC=0, imem returns 32'h2008_0005 at 0 -> after 1 edge ifid_instr=32'h2008_0005, ifid_pc4=4, ifid_valid=1, imem_addr=4.
REQ-035 ifid_instr=32'h0800_0040, ifid_pc4=32'h0000_0010, SEL_DIR=01, resetIF=1 -> next edge imem_addr=32'h0000_0100, ifid_valid=0, flush_cnt=1.
REQ-036 SEL_DIR=10, resetIF=1, jr_addr=32'h0000_0203 -> imem_addr=32'h0000_0200, IF/ID bubbled.
REQ-037 stall=1 for 3 edges with SEL_DIR=01, resetIF=1 -> PC, IF/ID, flush_cnt unchanged, imem_rd_n=1; stall drop -> redirect on next edge.
REQ-038 PC=32'hFFFF_FFFC sequential -> PC=0; flush_cnt preset 16'hFFFF plus flush -> stays 16'hFFFF.
REQ-039 rst_n asserted between edges during redirect -> outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/etapa_if_pkg.sv
// Shared processor constants: reset PC, bubble word and next-PC select encodings.
// Imported by the fetch stage and the control decoder.
package etapa_if_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] BUBBLE_DEF   = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_PC4  = 2'b00,
        SEL_J    = 2'b01,
        SEL_JR   = 2'b10,
        SEL_RSVD = 2'b11
    } sel_dir_t;

    function automatic logic [31:0] j_target(input logic [31:0] pc4, input logic [31:0] instr);
        return {pc4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/etapa_if_pc_next.sv
// Combinational next-PC mux: sequential PC+4, j target from IF/ID, or word-aligned jr target.
module pc_next
    import etapa_if_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  sel_dir,
    input  logic [31:0] ifid_pc4,
    input  logic [31:0] ifid_instr,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc_plus4,
    output logic [31:0] pc_nxt
);

    assign pc_plus4 = pc + 32'd4;

    // The reserved encoding falls through to the sequential path.
    always_comb begin
        pc_nxt = pc_plus4;
        if (sel_dir == SEL_J)
            pc_nxt = j_target(ifid_pc4, ifid_instr);
        else if (sel_dir == SEL_JR)
            pc_nxt = {jr_addr[31:2], 2'b00};
    end

endmodule

// File: rtl/etapa_if.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and flush counter.
// Stall freezes everything; a flush bubbles IF/ID while the PC still takes its new target.
module etapa_if
    import etapa_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] BUBBLE   = BUBBLE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  SEL_DIR,
    input  logic        resetIF,
    input  logic        stall,
    input  logic [31:0] jr_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] imem_addr,
    output logic        imem_rd_n,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [15:0] flush_cnt
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_nxt;

    pc_next u_pc_next (
        .pc         (pc),
        .sel_dir    (SEL_DIR),
        .ifid_pc4   (ifid_pc4),
        .ifid_instr (ifid_instr),
        .jr_addr    (jr_addr),
        .pc_plus4   (pc_plus4),
        .pc_nxt     (pc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            ifid_instr <= BUBBLE;
            ifid_pc4   <= 32'h0;
            ifid_valid <= 1'b0;
            flush_cnt  <= 16'h0;
        end else if (!stall) begin
            pc <= pc_nxt;
            if (resetIF) begin
                ifid_instr <= BUBBLE;
                ifid_pc4   <= 32'h0;
                ifid_valid <= 1'b0;
                if (flush_cnt != 16'hFFFF)
                    flush_cnt <= flush_cnt + 16'd1;
            end else begin
                ifid_instr <= imem_data;
                ifid_pc4   <= pc_plus4;
                ifid_valid <= 1'b1;
            end
        end
    end

    // Read enable drops with rst_n directly so reset is visible without a clock.
    assign imem_rd_n = ~rst_n | stall;
    assign imem_addr = pc;
    assign opcode    = ifid_instr[31:26];
    assign funct     = ifid_instr[5:0];

endmodule

// File: tb/tb_etapa_if.sv
// Self-checking bench for etapa_if: behavioural fetch model, directed corner cases and random traffic.
module tb_etapa_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  SEL_DIR;
    logic        resetIF;
    logic        stall;
    logic [31:0] jr_addr;
    logic [31:0] imem_data;
    logic [31:0] imem_addr;
    logic        imem_rd_n;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] flush_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    etapa_if dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .SEL_DIR    (SEL_DIR),
        .resetIF    (resetIF),
        .stall      (stall),
        .jr_addr    (jr_addr),
        .imem_data  (imem_data),
        .imem_addr  (imem_addr),
        .imem_rd_n  (imem_rd_n),
        .ifid_instr (ifid_instr),
        .ifid_pc4   (ifid_pc4),
        .ifid_valid (ifid_valid),
        .opcode     (opcode),
        .funct      (funct),
        .flush_cnt  (flush_cnt)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        if (a == 32'hC) return 32'h0800_0040;
        return ((a ^ 32'hA5A5_0000) * 32'h0001_0003) + 32'h1357;
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 16'h0;
    endtask

    task automatic check_all();
        chk("imem_addr", imem_addr, m_pc);
        chk("imem_rd_n", {31'b0, imem_rd_n}, {31'b0, (~rst_n) | stall});
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_pc4", ifid_pc4, m_pc4);
        chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
        chk("opcode", {26'b0, opcode}, {26'b0, m_instr[31:26]});
        chk("funct", {26'b0, funct}, {26'b0, m_instr[5:0]});
        chk("flush_cnt", {16'b0, flush_cnt}, {16'b0, m_cnt});
    endtask

    // Apply inputs for one edge, advance the model from the rules, then compare after the edge.
    task automatic step(input logic [1:0] sel, input logic rif, input logic st, input logic [31:0] jr);
        logic [31:0] tgt;
        SEL_DIR = sel; resetIF = rif; stall = st; jr_addr = jr;
        if (!st) begin
            case (sel)
                2'b01:   tgt = {m_pc4[31:28], m_instr[25:0], 2'b00};
                2'b10:   tgt = jr & 32'hFFFF_FFFC;
                default: tgt = m_pc + 32'd4;
            endcase
            if (rif) begin
                m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end else begin
                m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            end
            m_pc = tgt;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; SEL_DIR = 2'b00; resetIF = 1'b0; stall = 1'b0; jr_addr = 32'h0;
        model_reset();
        #12;
        check_all();
        chk("reset_rd_n", {31'b0, imem_rd_n}, 32'd1);
        rst_n = 1'b1;   // released between edges (t=12, edges at 5/15/...)
        #1;

        // First fetch from RESET_PC.
        step(2'b00, 1'b0, 1'b0, 32'h0);
        chk("first_instr", ifid_instr, 32'h2008_0005);
        chk("first_pc4", ifid_pc4, 32'h4);
        chk("first_valid", {31'b0, ifid_valid}, 32'd1);
        chk("first_addr", imem_addr, 32'h4);

        // Walk to the j at 0xC, then take it with a flush.
        step(2'b00, 1'b0, 1'b0, 32'h0);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        chk("j_instr", ifid_instr, 32'h0800_0040);
        chk("j_pc4", ifid_pc4, 32'h10);
        step(2'b01, 1'b1, 1'b0, 32'h0);
        chk("j_target", imem_addr, 32'h100);
        chk("j_bubble", {31'b0, ifid_valid}, 32'd0);
        chk("j_cnt", {16'b0, flush_cnt}, 32'd1);

        step(2'b10, 1'b1, 1'b0, 32'h0000_0203);
        chk("jr_target", imem_addr, 32'h200);
        chk("jr_bubble", ifid_instr, 32'h0);
        chk("jr_cnt", {16'b0, flush_cnt}, 32'd2);

        for (int i = 0; i < 3; i++) begin
            step(2'b01, 1'b1, 1'b1, 32'h0);
            chk("stall_addr", imem_addr, 32'h200);
            chk("stall_cnt", {16'b0, flush_cnt}, 32'd2);
            chk("stall_rd_n", {31'b0, imem_rd_n}, 32'd1);
        end
        step(2'b01, 1'b1, 1'b0, 32'h0);
        chk("post_stall_cnt", {16'b0, flush_cnt}, 32'd3);
        chk("post_stall_addr", imem_addr, 32'h0);

        // Reserved select behaves sequentially and loads IF/ID.
        step(2'b11, 1'b0, 1'b0, 32'h0);
        chk("rsvd_addr", imem_addr, 32'h4);
        chk("rsvd_valid", {31'b0, ifid_valid}, 32'd1);

        // PC wrap.
        step(2'b10, 1'b0, 1'b0, 32'hFFFF_FFFF);
        chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pc4", ifid_pc4, 32'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), $urandom);
        end

        // Saturate the flush counter.
        for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++)
            step(2'b00, 1'b1, 1'b0, 32'h0);
        chk("sat_reach", {16'b0, flush_cnt}, 32'h0000_FFFF);
        step(2'b01, 1'b1, 1'b0, 32'h0);
        chk("sat_hold", {16'b0, flush_cnt}, 32'h0000_FFFF);

        // Asynchronous reset in the middle of a redirect, between edges.
        step(2'b00, 1'b0, 1'b0, 32'h0);
        SEL_DIR = 2'b10; resetIF = 1'b1; jr_addr = 32'h0000_0ABC;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_cnt", {16'b0, flush_cnt}, 32'd0);
        chk("async_addr", imem_addr, 32'h0);
        chk("async_rd_n", {31'b0, imem_rd_n}, 32'd1);
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        step(2'b00, 1'b0, 1'b0, 32'h0);
        chk("rerelease_instr", ifid_instr, 32'h2008_0005);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
